// File: rtl/spare_ctrl_pkg.sv
// Shared constants, FSM state type and select helper for the spare SRAM controller.
package spare_ctrl_pkg;

  localparam int unsigned MAIN_ADDR_W = 12;
  localparam int unsigned NSPARE      = 25;
  localparam int unsigned ROW_W       = 7;
  localparam int unsigned BLK_W       = MAIN_ADDR_W - ROW_W;
  localparam int unsigned IDX_W       = 5;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StRead,
    StDone
  } state_e;

  // Active-low one-hot bank select.
  function automatic logic [NSPARE-1:0] sel_n(input logic [IDX_W-1:0] idx);
    logic [NSPARE-1:0] onehot;
    onehot = NSPARE'(1) << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/spare_sram_ctrl_if.sv
// Request, fault-report and spare-array pin bundle of the spare SRAM controller.
interface spare_sram_ctrl_if #(
  parameter int unsigned ADDR_W = spare_ctrl_pkg::MAIN_ADDR_W
);

  logic                                    REG_VALID;
  logic [ADDR_W-spare_ctrl_pkg::ROW_W-1:0] REG_BLK;
  logic                                    REG_FULL;
  logic                                    REQ_VALID;
  logic                                    REQ_READY;
  logic                                    REQ_WE;
  logic [ADDR_W-1:0]                       REQ_ADDR;
  logic [7:0]                              REQ_WDATA;
  logic                                    RSP_VALID;
  logic                                    RSP_HIT;
  logic [7:0]                              RSP_RDATA;
  logic [spare_ctrl_pkg::ROW_W-1:0]        MEM_ADDR;
  logic                                    MEM_CE;
  logic                                    MEM_WEB;
  logic [spare_ctrl_pkg::NSPARE-1:0]       MEM_OEB;
  logic [spare_ctrl_pkg::NSPARE-1:0]       MEM_CSB;
  logic [7:0]                              MEM_IDATA;
  logic [7:0]                              SPARE_ODATA;

  modport slave (
    input  REG_VALID, REG_BLK, REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, SPARE_ODATA,
    output REG_FULL, REQ_READY, RSP_VALID, RSP_HIT, RSP_RDATA,
    output MEM_ADDR, MEM_CE, MEM_WEB, MEM_OEB, MEM_CSB, MEM_IDATA
  );

  modport master (
    output REG_VALID, REG_BLK, REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, SPARE_ODATA,
    input  REG_FULL, REQ_READY, RSP_VALID, RSP_HIT, RSP_RDATA,
    input  MEM_ADDR, MEM_CE, MEM_WEB, MEM_OEB, MEM_CSB, MEM_IDATA
  );

endinterface

// File: rtl/spare_fault_cam.sv
// Fault table: maps faulty main-memory blocks to spare banks, allocated in report order.
module spare_fault_cam
  import spare_ctrl_pkg::*;
#(
  parameter int unsigned BlkW = BLK_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_reg_valid,
  input  logic [BlkW-1:0]  i_reg_blk,
  input  logic [BlkW-1:0]  i_lkp_blk,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_full
);

  logic [BlkW-1:0]   r_blk [NSPARE];
  logic [NSPARE-1:0] r_vld;
  logic [IDX_W-1:0]  r_ptr;
  logic              r_full;
  logic              w_dup;
  logic [NSPARE-1:0] w_match;

  // At most one entry can match, so OR-ing indices yields the matching one.
  always_comb begin
    w_dup   = 1'b0;
    w_match = '0;
    o_idx   = '0;
    for (int i = 0; i < NSPARE; i++) begin
      if (r_vld[i] && (r_blk[i] == i_reg_blk)) w_dup = 1'b1;
      w_match[i] = r_vld[i] && (r_blk[i] == i_lkp_blk);
      if (w_match[i]) o_idx = o_idx | IDX_W'(i);
    end
  end

  assign o_hit  = |w_match;
  assign o_full = r_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld  <= '0;
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else if (i_reg_valid && !w_dup) begin
      if (r_ptr < IDX_W'(NSPARE)) begin
        r_blk[r_ptr] <= i_reg_blk;
        r_vld[r_ptr] <= 1'b1;
        r_ptr        <= r_ptr + 1'b1;
      end else begin
        r_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spare_sram_ctrl.sv
// Spare SRAM controller: fault-table lookup, request FSM and registered spare-array pins.
module spare_sram_ctrl
  import spare_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = MAIN_ADDR_W
) (
  input  logic             CLK,
  input  logic             RSTN,
  spare_sram_ctrl_if.slave bus
);

  localparam int unsigned BlkW = ADDR_W - ROW_W;

  state_e            r_state, w_state_d;
  logic [ROW_W-1:0]  r_row, w_row_d;
  logic              r_we, w_we_d;
  logic [7:0]        r_wdata, w_wdata_d;
  logic              r_hit, w_hit_d;
  logic [IDX_W-1:0]  r_idx, w_idx_d;
  logic              w_cam_hit;
  logic [IDX_W-1:0]  w_cam_idx;

  logic [ROW_W-1:0]  r_mem_addr, w_mem_addr;
  logic              r_mem_ce, w_mem_ce;
  logic              r_mem_web, w_mem_web;
  logic [NSPARE-1:0] r_mem_oeb, w_mem_oeb;
  logic [NSPARE-1:0] r_mem_csb, w_mem_csb;
  logic [7:0]        r_mem_idata, w_mem_idata;
  logic              r_rsp_valid, r_rsp_hit, r_req_ready;
  logic [7:0]        r_rsp_rdata;

  spare_fault_cam #(
    .BlkW(BlkW)
  ) u_cam (
    .i_clk      (CLK),
    .i_rst_n    (RSTN),
    .i_reg_valid(bus.REG_VALID),
    .i_reg_blk  (bus.REG_BLK),
    .i_lkp_blk  (bus.REQ_ADDR[ADDR_W-1:ROW_W]),
    .o_hit      (w_cam_hit),
    .o_idx      (w_cam_idx),
    .o_full     (bus.REG_FULL)
  );

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_we_d    = r_we;
    w_wdata_d = r_wdata;
    w_hit_d   = r_hit;
    w_idx_d   = r_idx;
    case (r_state)
      StIdle: begin
        if (bus.REQ_VALID) begin
          w_row_d   = bus.REQ_ADDR[ROW_W-1:0];
          w_we_d    = bus.REQ_WE;
          w_wdata_d = bus.REQ_WDATA;
          w_hit_d   = w_cam_hit;
          w_idx_d   = w_cam_idx;
          w_state_d = w_cam_hit ? StSetup : StDone;
        end
      end
      StSetup:  w_state_d = StStrobe;
      StStrobe: w_state_d = r_we ? StDone : StRead;
      StRead:   w_state_d = StDone;
      default:  w_state_d = StIdle;
    endcase
  end

  // Pins are computed from the next state so each one is a plain flop output.
  always_comb begin
    w_mem_csb   = '1;
    w_mem_oeb   = '1;
    w_mem_ce    = 1'b0;
    w_mem_web   = 1'b1;
    w_mem_addr  = r_mem_addr;
    w_mem_idata = r_mem_idata;
    case (w_state_d)
      StSetup, StStrobe: begin
        w_mem_csb   = sel_n(w_idx_d);
        w_mem_addr  = w_row_d;
        w_mem_idata = w_wdata_d;
        w_mem_web   = ~w_we_d;
        w_mem_ce    = (w_state_d == StStrobe);
      end
      StRead: begin
        w_mem_csb = sel_n(w_idx_d);
        w_mem_oeb = sel_n(w_idx_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state     <= StIdle;
      r_row       <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_hit       <= 1'b0;
      r_idx       <= '0;
      r_mem_addr  <= '0;
      r_mem_ce    <= 1'b0;
      r_mem_web   <= 1'b1;
      r_mem_oeb   <= '1;
      r_mem_csb   <= '1;
      r_mem_idata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_rdata <= '0;
      r_req_ready <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_row       <= w_row_d;
      r_we        <= w_we_d;
      r_wdata     <= w_wdata_d;
      r_hit       <= w_hit_d;
      r_idx       <= w_idx_d;
      r_mem_addr  <= w_mem_addr;
      r_mem_ce    <= w_mem_ce;
      r_mem_web   <= w_mem_web;
      r_mem_oeb   <= w_mem_oeb;
      r_mem_csb   <= w_mem_csb;
      r_mem_idata <= w_mem_idata;
      r_rsp_valid <= (w_state_d == StDone);
      r_rsp_hit   <= (w_state_d == StDone) && w_hit_d;
      r_rsp_rdata <= (r_state == StRead) ? bus.SPARE_ODATA : 8'h00;
      r_req_ready <= (w_state_d == StIdle);
    end
  end

  assign bus.MEM_ADDR  = r_mem_addr;
  assign bus.MEM_CE    = r_mem_ce;
  assign bus.MEM_WEB   = r_mem_web;
  assign bus.MEM_OEB   = r_mem_oeb;
  assign bus.MEM_CSB   = r_mem_csb;
  assign bus.MEM_IDATA = r_mem_idata;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_HIT   = r_rsp_hit;
  assign bus.RSP_RDATA = r_rsp_rdata;
  assign bus.REQ_READY = r_req_ready;

endmodule

// File: tb/tb_spare_sram_ctrl.sv
// Scoreboard bench for spare_sram_ctrl with a behavioural model of the 25-bank spare array.
module tb_spare_sram_ctrl;
  import spare_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  spare_sram_ctrl_if #(.ADDR_W(12)) bus ();

  spare_sram_ctrl #(.ADDR_W(12)) dut (
    .CLK (clk),
    .RSTN(rstn),
    .bus (bus)
  );

  typedef struct {
    logic       hit;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Spare array model: latches on CE rising edge, drives data while OEB is low.
  logic [7:0] mem  [NSPARE][128];
  logic [7:0] dout [NSPARE];

  always @(posedge bus.MEM_CE) begin
    for (int b = 0; b < NSPARE; b++) begin
      if (!bus.MEM_CSB[b]) begin
        if (!bus.MEM_WEB) mem[b][bus.MEM_ADDR] <= bus.MEM_IDATA;
        else dout[b] <= mem[b][bus.MEM_ADDR];
      end
    end
  end

  always_comb begin
    bus.SPARE_ODATA = 8'h00;
    for (int b = 0; b < NSPARE; b++) begin
      if (!bus.MEM_OEB[b]) bus.SPARE_ODATA = bus.SPARE_ODATA | dout[b];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && bus.RSP_VALID === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: RSP_VALID high with nothing pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_hit", 32'(bus.RSP_HIT), 32'(e.hit));
          chk("rsp_rdata", 32'(bus.RSP_RDATA), 32'(e.rdata));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rstn = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.REG_VALID = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic reg_blk(input logic [4:0] b);
    bus.REG_VALID = 1'b1;
    bus.REG_BLK   = b;
    @(negedge clk);
    bus.REG_VALID = 1'b0;
  endtask

  // Issues one request; returns at the negedge of cycle T+1.
  task automatic do_req(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                        input logic ehit, input logic [7:0] erd, input bit track);
    int   n;
    exp_t e;
    n = 0;
    while (bus.REQ_READY !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.REQ_READY !== 1'b1) begin
      n_chk++;
      n_err++;
      $display("FAIL ready_timeout: REQ_READY got %b, required 1", bus.REQ_READY);
    end
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wd;
    if (track) begin
      e.hit   = ehit;
      e.rdata = erd;
      e.cyc   = cyc + (!ehit ? 1 : (we ? 3 : 4));
      q.push_back(e);
    end
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bus.REQ_VALID = 1'b0;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WDATA = '0;
    bus.REG_VALID = 1'b0;
    bus.REG_BLK   = '0;
    rstn          = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state.
    chk("rst_csb", 32'(bus.MEM_CSB), 32'h1FFFFFF);
    chk("rst_oeb", 32'(bus.MEM_OEB), 32'h1FFFFFF);
    chk("rst_web", 32'(bus.MEM_WEB), 32'h1);
    chk("rst_ce", 32'(bus.MEM_CE), 32'h0);
    chk("rst_addr", 32'(bus.MEM_ADDR), 32'h0);
    chk("rst_idata", 32'(bus.MEM_IDATA), 32'h0);
    chk("rst_rsp", 32'({bus.RSP_VALID, bus.RSP_HIT, bus.RSP_RDATA}), 32'h0);
    chk("rst_full", 32'(bus.REG_FULL), 32'h0);
    chk("rst_ready", 32'(bus.REQ_READY), 32'h1);

    // 1: empty table, read misses.
    do_req(1'b0, 12'h123, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("miss_csb", 32'(bus.MEM_CSB), 32'h1FFFFFF);
    chk("miss_ready", 32'(bus.REQ_READY), 32'h0);
    drain();

    // 2: block 0x05 -> bank 0; write then read back.
    reg_blk(5'h05);
    do_req(1'b1, 12'h2A3, 8'hA5, 1'b1, 8'h00, 1'b1);
    chk("wr_csb", 32'(bus.MEM_CSB), 32'h1FFFFFE);
    chk("wr_addr", 32'(bus.MEM_ADDR), 32'h23);
    chk("wr_web", 32'(bus.MEM_WEB), 32'h0);
    chk("wr_idata", 32'(bus.MEM_IDATA), 32'hA5);
    chk("wr_ce_setup", 32'(bus.MEM_CE), 32'h0);
    @(negedge clk);
    chk("wr_ce_strobe", 32'(bus.MEM_CE), 32'h1);
    @(negedge clk);
    chk("wr_ce_done", 32'(bus.MEM_CE), 32'h0);
    chk("wr_csb_done", 32'(bus.MEM_CSB), 32'h1FFFFFF);
    drain();
    do_req(1'b0, 12'h2A3, 8'h00, 1'b1, 8'hA5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("rd_oeb", 32'(bus.MEM_OEB), 32'h1FFFFFE);
    chk("rd_web", 32'(bus.MEM_WEB), 32'h1);
    drain();

    // 3: fill all 25 banks, then overflow.
    do_reset();
    for (int b = 0; b < NSPARE; b++) reg_blk(5'(b));
    chk("full_before", 32'(bus.REG_FULL), 32'h0);
    reg_blk(5'd25);
    chk("full_after", 32'(bus.REG_FULL), 32'h1);
    do_req(1'b1, 12'hC11, 8'h3C, 1'b1, 8'h00, 1'b1);
    chk("bank24_csb", 32'(bus.MEM_CSB), 32'h0FFFFFF);
    drain();
    do_req(1'b0, 12'hC11, 8'h00, 1'b1, 8'h3C, 1'b1);
    drain();
    do_req(1'b0, 12'hC82, 8'h00, 1'b0, 8'h00, 1'b1);
    drain();
    chk("full_sticky", 32'(bus.REG_FULL), 32'h1);

    // 4: duplicate report is ignored.
    do_reset();
    chk("full_cleared", 32'(bus.REG_FULL), 32'h0);
    reg_blk(5'h07);
    reg_blk(5'h07);
    reg_blk(5'h08);
    do_req(1'b1, 12'h410, 8'h5A, 1'b1, 8'h00, 1'b1);
    chk("dup_csb", 32'(bus.MEM_CSB), 32'h1FFFFFD);
    drain();
    do_req(1'b0, 12'h410, 8'h00, 1'b1, 8'h5A, 1'b1);
    drain();

    // 5: same-cycle registration and request -> miss, then hit.
    do_reset();
    bus.REG_VALID = 1'b1;
    bus.REG_BLK   = 5'h09;
    do_req(1'b0, 12'h485, 8'h00, 1'b0, 8'h00, 1'b1);
    bus.REG_VALID = 1'b0;
    drain();
    do_req(1'b1, 12'h485, 8'h77, 1'b1, 8'h00, 1'b1);
    chk("same_cyc_csb", 32'(bus.MEM_CSB), 32'h1FFFFFE);
    drain();
    do_req(1'b0, 12'h485, 8'h00, 1'b1, 8'h77, 1'b1);
    drain();

    // 6: reset during STROBE drops the access.
    do_reset();
    reg_blk(5'h03);
    do_req(1'b1, 12'h18A, 8'h55, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    chk("mid_ce_strobe", 32'(bus.MEM_CE), 32'h1);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_csb", 32'(bus.MEM_CSB), 32'h1FFFFFF);
    chk("mid_oeb", 32'(bus.MEM_OEB), 32'h1FFFFFF);
    chk("mid_ce", 32'(bus.MEM_CE), 32'h0);
    chk("mid_rsp_valid", 32'(bus.RSP_VALID), 32'h0);
    chk("mid_ready", 32'(bus.REQ_READY), 32'h1);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    do_req(1'b0, 12'h18A, 8'h00, 1'b0, 8'h00, 1'b1);
    drain();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
